// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared MMIO offsets, STATUS bit positions and default window base
package dmem_pkg;

    localparam logic [7:0] OFF_COUNT  = 8'h00;
    localparam logic [7:0] OFF_TXDATA = 8'h04;
    localparam logic [7:0] OFF_STATUS = 8'h08;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVF       = 2;
    localparam int ST_COUNT_LSB = 8;

    localparam logic [31:0] DEF_MMIO_BASE = 32'hFFFF_FF00;

endpackage

// File: rtl/data_mem_responder_fifo.sv
// rtl/data_mem_responder_fifo.sv - registered sync FIFO; a push while full is accepted only alongside a pop
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-cycle data-memory responder: word RAM plus MMIO counter and TX FIFO
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH      = 1024,
    parameter int          FIFO_DEPTH = 16,
    parameter logic [31:0] MMIO_BASE  = DEF_MMIO_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic [31:0] address_to_mem,
    input  logic [31:0] data_to_mem,
    output logic [31:0] data_from_mem,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   ram [DEPTH];
    logic [31:0]   cycle_cnt;
    logic          overflow;
    logic [AW-1:0] word_idx;
    logic [7:0]    offset;
    logic          is_ram;
    logic          mmio_hit;
    logic          misaligned;
    logic          wr_count;
    logic          wr_txdata;
    logic          wr_status;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    // Low address bits are dropped so misaligned accesses hit the containing word.
    assign word_idx   = address_to_mem[AW+1:2];
    assign offset     = {address_to_mem[7:2], 2'b00};
    assign is_ram     = (address_to_mem < 32'(4 * DEPTH));
    assign mmio_hit   = !is_ram && (address_to_mem[31:8] == MMIO_BASE[31:8]);
    assign misaligned = (address_to_mem[1:0] != 2'b00);

    assign wr_count  = WE && mmio_hit && (offset == OFF_COUNT);
    assign wr_txdata = WE && mmio_hit && (offset == OFF_TXDATA);
    assign wr_status = WE && mmio_hit && (offset == OFF_STATUS);
    assign tx_valid  = !fifo_empty;
    assign pop       = tx_valid && tx_ready;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txdata),
        .pop   (pop),
        .din   (data_to_mem[7:0]),
        .dout  (tx_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        status                        = '0;
        status[ST_EMPTY]              = fifo_empty;
        status[ST_FULL]               = fifo_full;
        status[ST_OVF]                = overflow;
        status[ST_COUNT_LSB +: 8]     = 8'(fifo_count);
    end

    always_comb begin
        data_from_mem = '0;
        if (is_ram) begin
            data_from_mem = ram[word_idx];
        end else if (mmio_hit) begin
            case (offset)
                OFF_COUNT:  data_from_mem = cycle_cnt;
                OFF_STATUS: data_from_mem = status;
                default:    data_from_mem = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (WE && is_ram) begin
            ram[word_idx] <= data_to_mem;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_cnt <= '0;
            overflow  <= 1'b0;
            bus_err   <= 1'b0;
        end else begin
            cycle_cnt <= wr_count ? data_to_mem : cycle_cnt + 32'd1;
            if (wr_txdata && fifo_full && !pop) begin
                overflow <= 1'b1;
            end else if (wr_status && data_to_mem[ST_OVF]) begin
                overflow <= 1'b0;
            end
            // The core drives an address every cycle, so unmapped reads are harmless.
            if (misaligned || (WE && !is_ram && !mmio_hit)) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder
module tb_data_mem_responder;
    localparam logic [31:0] MB     = 32'hFFFF_FF00;
    localparam logic [31:0] A_CNT  = MB + 32'h00;
    localparam logic [31:0] A_TXD  = MB + 32'h04;
    localparam logic [31:0] A_STAT = MB + 32'h08;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        bus_err;

    logic        rd_chk = 1'b0;
    logic [31:0] rd_q [$];
    logic [7:0]  tx_q [$];
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    data_mem_responder dut (
        .clk            (clk),
        .reset          (rst_n),
        .WE             (we),
        .address_to_mem (addr),
        .data_to_mem    (wdata),
        .data_from_mem  (rdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .bus_err        (bus_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input bit c, input logic [31:0] e);
        @(posedge clk);
        #1;
        we = w; addr = a; wdata = d; rd_chk = c;
        if (c) rd_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rd_chk) begin
            if (rd_q.size() == 0) chk("rd_q_empty", 32'd1, 32'd0);
            else chk("rdata", rdata, rd_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            if (tx_q.size() == 0) chk("tx_q_empty", {24'd0, tx_data}, 32'hxx);
            else chk("tx_byte", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
        end
    end

    task automatic drain(input string name);
        tx_ready = 1'b1;
        for (int i = 0; i < 40 && tx_valid; i++) step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk(name, {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // reset state: combinational reads see cleared counter and empty FIFO
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h0);
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h1);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        rst_n = 1'b1;

        // RAM write/read and read-during-write
        step(1'b1, 32'h14, 32'h1111_1111, 1'b0, 32'h0);
        step(1'b1, 32'h14, 32'h2222_2222, 1'b1, 32'h1111_1111);
        step(1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 32'h0);
        step(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 32'h14, 32'h0, 1'b1, 32'h2222_2222);
        chk("ram_bus_err", {31'd0, bus_err}, 32'd0);

        // counter load and wrap
        step(1'b1, A_CNT, 32'h100, 1'b0, 32'h0);
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h100);
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h101);
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h102);
        step(1'b1, A_CNT, 32'hFFFF_FFFF, 1'b0, 32'h0);
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'hFFFF_FFFF);
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h0);

        // fill past full, then drain in order
        for (int i = 1; i <= 17; i++) begin
            step(1'b1, A_TXD, 32'(i), (i == 1), 32'h0);
            if (i <= 16) tx_q.push_back(8'(i));
        end
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h0000_1006);
        drain("drain1_done");
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h0000_0005);
        chk("drain1_left", tx_q.size(), 32'd0);

        // push while full with a same-cycle pop is accepted
        for (int i = 0; i < 16; i++) begin
            step(1'b1, A_TXD, 32'h20 + 32'(i), 1'b0, 32'h0);
            tx_q.push_back(8'h20 + 8'(i));
        end
        step(1'b1, A_TXD, 32'hAA, 1'b0, 32'h0);
        tx_ready = 1'b1;
        tx_q.push_back(8'hAA);
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h0000_1006);
        tx_ready = 1'b0;
        step(1'b1, A_STAT, 32'h4, 1'b0, 32'h0);
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h0000_1002);
        step(1'b0, MB + 32'h0C, 32'h0, 1'b1, 32'h0);
        drain("drain2_done");
        chk("drain2_left", tx_q.size(), 32'd0);

        // unmapped and misaligned accesses
        step(1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0);
        step(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        chk("unmapped_rd_err", {31'd0, bus_err}, 32'd0);
        step(1'b1, 32'h8000_0000, 32'h5, 1'b0, 32'h0);
        step(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("unmapped_wr_err", {31'd0, bus_err}, 32'd1);
        step(1'b0, 32'h11, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 32'h10, 32'h0, 1'b0, 32'h0);
        chk("sticky_err", {31'd0, bus_err}, 32'd1);

        // reset mid-drain discards FIFO contents at once
        step(1'b1, A_TXD, 32'h31, 1'b0, 32'h0);
        step(1'b1, A_TXD, 32'h32, 1'b0, 32'h0);
        step(1'b1, A_TXD, 32'h33, 1'b0, 32'h0);
        tx_q.push_back(8'h31);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        tx_ready = 1'b1;
        step(1'b0, A_CNT, 32'h0, 1'b1, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_txv", {31'd0, tx_valid}, 32'd0);
        chk("rst_mid_err", {31'd0, bus_err}, 32'd0);
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h1);
        rst_n = 1'b1;
        step(1'b0, A_STAT, 32'h0, 1'b1, 32'h1);
        step(1'b0, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("post_rst_err", {31'd0, bus_err}, 32'd0);
        step(1'b0, 32'h12, 32'h0, 1'b1, 32'hDEAD_BEEF);
        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("misaligned_rd_err", {31'd0, bus_err}, 32'd1);
        tx_ready = 1'b0;

        step(1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
        chk("rd_q_left", rd_q.size(), 32'd0);
        chk("tx_q_left", tx_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
